// File: rtl/i2c_target_rx.sv
// Write-only I2C target: receives address, control byte and any number of data bytes,
// ACKing each byte and presenting the control and data bytes to the system side.
module i2c_target_rx #(
    parameter logic [6:0] TARGET_ADDR = 7'h3D
) (
    input  logic       clk1,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda,
    output logic       sda_oe,
    output logic [7:0] rx_ctrl,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       nack_evt
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, DATA, DATA_ACK, WAIT_STOP
    } state_t;

    state_t     state, state_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift_reg, shift_n;
    logic [7:0] rx_ctrl_n, rx_data_n;
    logic       sda_oe_n, rx_valid_n, nack_n;

    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;

    // NOTE: synchronizers reset to 1 so leaving reset on an idle bus never looks like START/STOP.
    always_ff @(posedge clk1) begin
        if (reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & ~sda_d & sda_s2;

    assign busy = (state == ADDR_ACK) || (state == CTRL) || (state == CTRL_ACK) ||
                  (state == DATA) || (state == DATA_ACK);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift_reg;
        sda_oe_n   = sda_oe;
        rx_ctrl_n  = rx_ctrl;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        nack_n     = 1'b0;

        if (stop_det) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
        end else if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
        end else begin
            case (state)
                ADDR, CTRL, DATA: begin
                    if (bit_cnt == 4'd8) begin
                        if (state == CTRL)
                            state_n = CTRL_ACK;
                        else if (state == DATA)
                            state_n = DATA_ACK;
                        else if (shift_reg == {TARGET_ADDR, 1'b0})
                            state_n = ADDR_ACK;
                        else begin
                            // Mismatch or read request: decline and sit out the transaction.
                            nack_n  = 1'b1;
                            state_n = WAIT_STOP;
                        end
                    end else if (scl_rise) begin
                        shift_n   = {shift_reg[6:0], sda_s2};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
                ADDR_ACK, CTRL_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_n = 1'b1;
                            if (state == CTRL_ACK)
                                rx_ctrl_n = shift_reg;
                            if (state == DATA_ACK) begin
                                rx_data_n  = shift_reg;
                                rx_valid_n = 1'b1;
                            end
                        end else begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = 4'd0;
                            state_n   = (state == ADDR_ACK) ? CTRL : DATA;
                        end
                    end
                end
                default: sda_oe_n = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk1) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shift_reg <= 8'h00;
            sda_oe    <= 1'b0;
            rx_ctrl   <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            nack_evt  <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_n;
            sda_oe    <= sda_oe_n;
            rx_ctrl   <= rx_ctrl_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            nack_evt  <= nack_n;
        end
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: an I2C master model drives directed and random write transactions;
// expected bytes, ACKs and pulse counts come from a transaction-level model.
module tb_i2c_target_rx;

    localparam time Q = 80ns;  // quarter SCL period

    logic       clk1 = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_oe;
    logic [7:0] rx_ctrl, rx_data;
    logic       rx_valid, busy, nack_evt;
    wire        sda_bus = m_sda & ~sda_oe;

    i2c_target_rx dut (
        .clk1    (clk1),
        .reset   (reset),
        .scl     (scl),
        .sda     (sda_bus),
        .sda_oe  (sda_oe),
        .rx_ctrl (rx_ctrl),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy),
        .nack_evt(nack_evt)
    );

    always #5ns clk1 = ~clk1;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Bus-side event monitor.
    int         valid_cnt = 0;
    int         nack_cnt  = 0;
    int         ack_cnt   = 0;
    logic       prev_oe   = 1'b0;
    logic [7:0] got_q[$];

    always @(negedge clk1) begin
        if (rx_valid) begin
            valid_cnt++;
            got_q.push_back(rx_data);
        end
        if (nack_evt) nack_cnt++;
        if (sda_oe && !prev_oe) ack_cnt++;
        prev_oe = sda_oe;
    end

    // Reference model state.
    logic [7:0] exp_ctrl = 8'h00;
    logic [7:0] exp_data = 8'h00;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; #Q;
        scl = 1'b1;   #Q;
        m_sda = 1'b0; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q;
        scl = 1'b1;   #Q;
        m_sda = 1'b1; #Q;
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; #Q;
        scl = 1'b1; #(2*Q);
        scl = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; #Q;
        scl = 1'b1;   #Q;
        ack = (sda_bus == 1'b0);
        #Q;
        scl = 1'b0;   #Q;
    endtask

    // One write transaction: START, address, and (only if addressed) control plus n data bytes, STOP.
    task automatic run_txn(input string tag, input logic [7:0] addr, input logic [7:0] ctrl,
                           input logic [7:0] d [0:3], input int n);
        logic ack;
        logic match;
        int   v0, n0, a0, q0;
        match = (addr == 8'h7A);
        v0 = valid_cnt; n0 = nack_cnt; a0 = ack_cnt; q0 = got_q.size();
        i2c_start();
        send_byte(addr, ack);
        check({tag, ".addr_ack"}, ack, match);
        check({tag, ".busy_mid"}, busy, match);
        if (match) begin
            send_byte(ctrl, ack);
            check({tag, ".ctrl_ack"}, ack, 1'b1);
            for (int i = 0; i < n; i++) begin
                send_byte(d[i], ack);
                check({tag, ".data_ack"}, ack, 1'b1);
                exp_q.push_back(d[i]);
            end
            exp_ctrl = ctrl;
            exp_data = d[n-1];
        end
        i2c_stop();
        repeat (10) @(negedge clk1);
        check({tag, ".nack_cnt"}, nack_cnt - n0, match ? 0 : 1);
        check({tag, ".ack_cnt"}, ack_cnt - a0, match ? n + 2 : 0);
        check({tag, ".valid_cnt"}, valid_cnt - v0, match ? n : 0);
        check({tag, ".rx_ctrl"}, rx_ctrl, exp_ctrl);
        check({tag, ".rx_data"}, rx_data, exp_data);
        check({tag, ".busy_end"}, busy, 1'b0);
        check({tag, ".sda_oe_end"}, sda_oe, 1'b0);
        if (match) begin
            for (int i = 0; i < n; i++) begin
                if (got_q.size() > q0 + i) check({tag, ".byte"}, got_q[q0+i], exp_q[exp_q.size()-n+i]);
                else check({tag, ".byte_missing"}, 1'b0, 1'b1);
            end
        end
    endtask

    initial begin
        logic [7:0] d [0:3];
        logic       ack;
        int         v0;

        // Reset state.
        repeat (4) @(negedge clk1);
        check("rst.sda_oe", sda_oe, 1'b0);
        check("rst.rx_ctrl", rx_ctrl, 8'h00);
        check("rst.rx_data", rx_data, 8'h00);
        check("rst.rx_valid", rx_valid, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.nack", nack_evt, 1'b0);
        reset = 1'b0;
        repeat (4) @(negedge clk1);
        check("rst.no_false_evt", valid_cnt + nack_cnt + ack_cnt, 0);

        // Single data byte.
        d = '{8'hA5, 8'h00, 8'h00, 8'h00};
        run_txn("basic", 8'h7A, 8'h00, d, 1);

        // Wrong address.
        d = '{8'h55, 8'h00, 8'h00, 8'h00};
        run_txn("wrong_addr", 8'h7C, 8'h99, d, 1);

        // Read request: NACK, then ignored until STOP.
        i2c_start();
        send_byte(8'h7B, ack);
        repeat (2) @(negedge clk1);
        check("read.ack", ack, 1'b0);
        check("read.busy", busy, 1'b0);
        send_byte(8'hFF, ack);
        check("read.ignored", ack, 1'b0);
        i2c_stop();
        repeat (10) @(negedge clk1);
        check("read.busy_end", busy, 1'b0);

        // Several data bytes.
        d = '{8'h11, 8'h22, 8'h00, 8'h00};
        run_txn("multi", 8'h7A, 8'h40, d, 2);

        // Partial byte abandoned by repeated START.
        v0 = valid_cnt;
        i2c_start();
        send_byte(8'h7A, ack);
        send_byte(8'h00, ack);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        d = '{8'h3C, 8'h00, 8'h00, 8'h00};
        run_txn("restart", 8'h7A, 8'h00, d, 1);
        check("restart.total_valid", valid_cnt - v0, 1);

        // Reset while the target is driving ACK.
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : 1'(8'h7A >> i));
        m_sda = 1'b1; #Q;
        scl = 1'b1;   #Q;
        @(negedge clk1);
        check("rstack.oe_before", sda_oe, 1'b1);
        reset = 1'b1;
        @(negedge clk1);
        check("rstack.sda_oe", sda_oe, 1'b0);
        check("rstack.rx_ctrl", rx_ctrl, 8'h00);
        check("rstack.rx_data", rx_data, 8'h00);
        check("rstack.busy", busy, 1'b0);
        check("rstack.rx_valid", rx_valid, 1'b0);
        reset = 1'b0;
        exp_ctrl = 8'h00;
        exp_data = 8'h00;
        #Q;
        scl = 1'b0; #Q;
        i2c_stop();
        repeat (4) @(negedge clk1);
        d = '{8'h5A, 8'hC3, 8'h00, 8'h00};
        run_txn("after_rst", 8'h7A, 8'h81, d, 2);

        // Random transactions.
        for (int t = 0; t < 10; t++) begin
            logic [7:0] a;
            int         n;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h7A;
            n = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
            run_txn("rand", a, 8'($urandom), d, n);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/i2c_target_rx.md
I2C_TARGET_RX -- requirements
Module: i2c_target_rx

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 7'h3D, the 7-bit bus address this target answers (write byte 8'h7A on the wire).
REQ-002 SHALL have port clk1  input  1  system clock, at least 8x the SCL rate.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port scl  input  1  raw bus clock, asynchronous to clk1.
REQ-005 SHALL have port sda  input  1  raw bus data, asynchronous to clk1.
REQ-006 SHALL have port sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
REQ-007 SHALL have port rx_ctrl  output  8  control byte of the current transaction.
REQ-008 SHALL have port rx_data  output  8  most recent data byte.
REQ-009 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-010 SHALL have port busy  output  1  high from accepted address to STOP/START.
REQ-011 SHALL have port nack_evt  output  1  one-cycle pulse when the target declines an address.

Function
REQ-012 SHALL pass scl and sda through two-flop synchronizers and one edge-detect register; all bus events act on the synchronized values.
REQ-013 SHALL detect START as synchronized sda falling while synchronized scl is high, and STOP as sda rising while scl is high.
REQ-014 SHALL sample one bit, MSB first, on each synchronized scl rising edge that is not part of a START or STOP.
REQ-015 SHALL implement the states IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, DATA, DATA_ACK and WAIT_STOP.
REQ-016 SHALL move from any state to ADDR on START, clear the bit counter to 0, and keep the previous rx_ctrl and rx_data values.
REQ-017 SHALL move from any state to IDLE on STOP and set sda_oe to 0 in the same cycle.
REQ-018 In ADDR, after 8 bits, SHALL move to ADDR_ACK if bits[7:1]==TARGET_ADDR and bit0==0; otherwise SHALL pulse nack_evt and move to WAIT_STOP with sda_oe held at 0.
REQ-019 A read request (address match, bit0==1) SHALL be declined as in REQ-018.
REQ-020 In each *_ACK state, SHALL set sda_oe to 1 on the first scl falling edge after the 8th bit and set it back to 0 on the next scl falling edge (end of the 9th clock).
REQ-021 When the ACK is released, SHALL move ADDR_ACK->CTRL, CTRL_ACK->DATA and DATA_ACK->DATA, clearing the bit counter each time.
REQ-022 SHALL load the shifted byte into rx_ctrl on the cycle sda_oe rises in CTRL_ACK.
REQ-023 SHALL load the shifted byte into rx_data and pulse rx_valid on the cycle sda_oe rises in DATA_ACK; one pulse per byte; multiple data bytes per transaction are allowed.
REQ-024 SHALL hold busy high in ADDR_ACK, CTRL, CTRL_ACK, DATA and DATA_ACK, and low in all other states.
REQ-025 The bit counter SHALL be 4 bits wide, count 0..8, and never wrap.
REQ-026 A STOP or START mid-byte SHALL abandon the partial byte, with no rx_valid and no change to rx_ctrl or rx_data.
REQ-027 In WAIT_STOP and IDLE, SHALL ignore scl edges and keep sda_oe at 0.
REQ-028 If START or STOP coincides with an scl edge in the same cycle, START/STOP SHALL take priority.

Reset
REQ-029 While reset is high, at the clk1 edge the block SHALL enter IDLE, clear the bit counter and shift register, and drive sda_oe=0, rx_ctrl=8'h00, rx_data=8'h00, rx_valid=0, busy=0 and nack_evt=0.
REQ-030 Reset mid-transaction SHALL release SDA immediately (sda_oe=0 the cycle after reset is sampled), and the block SHALL wait for the next START.
REQ-031 Synchronizer flops SHALL reset to 1 (idle bus), so that deasserting reset with the bus idle does not produce a false START or STOP.

Verification
REQ-032 Send START, 8'h7A, 8'h00, 8'hA5, STOP -> three ACK pulses, rx_ctrl=8'h00, rx_data=8'hA5, exactly one rx_valid, busy low after STOP.
REQ-033 Send START, 8'h7C, STOP -> nack_evt pulses once, sda_oe stays 0 throughout, rx_ctrl and rx_data unchanged.
REQ-034 Send START, 8'h7B (read request) -> NACK, nack_evt=1, state WAIT_STOP, then STOP -> IDLE.
REQ-035 Send START, 8'h7A, 8'h40, 8'h11, 8'h22, STOP -> rx_ctrl=8'h40, two rx_valid pulses with rx_data 8'h11 then 8'h22.
REQ-036 Send START, 8'h7A, 8'h00, 4 data bits, then repeated START, 8'h7A, 8'h00, 8'h3C, STOP -> no rx_valid for the partial byte, rx_data=8'h3C.
REQ-037 Assert reset while sda_oe=1 during an ACK -> sda_oe=0 the next cycle, all outputs at reset values, and the next full transaction is received correctly.
